// File: rtl/approx_error_monitor_pkg.sv
// approx_eval_pkg: shared state encoding, default sizing and width helper for approximate-logic evaluation
package approx_eval_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, SAMPLE, DONE} state_t;

    localparam int DEF_N_IN = 7;
    localparam int DEF_N_OUT = 4;
    localparam int DEF_SETTLE = 1;
    localparam int NUM_VEC = 1 << DEF_N_IN;

    function automatic int sum_width(input int n_in, input int per_vec_bits);
        return n_in + per_vec_bits;
    endfunction

endpackage

// File: rtl/approx_error_monitor_metric.sv
// error_metric_unit: per-vector mismatch flag, Hamming distance and unsigned absolute difference
module error_metric_unit #(
    parameter int N_OUT = 4
) (
    input  logic [N_OUT-1:0]             exact_po,
    input  logic [N_OUT-1:0]             approx_po,
    output logic                         mismatch,
    output logic [$clog2(N_OUT+1)-1:0]   hd,
    output logic [N_OUT-1:0]             abs_diff
);
    localparam int PW = $clog2(N_OUT+1);

    logic [N_OUT-1:0] diff_bits;

    assign diff_bits = approx_po ^ exact_po;
    assign mismatch = |diff_bits;
    assign abs_diff = approx_po >= exact_po ? approx_po - exact_po : exact_po - approx_po;

    // popcount of the differing bit positions
    always_comb begin
        hd = '0;
        for (int i = 0; i < N_OUT; i++) hd = hd + PW'(diff_bits[i]);
    end

endmodule

// File: rtl/approx_error_monitor.sv
// approx_error_monitor: exhaustive input sweep with on-chip error metric accumulation
module approx_error_monitor
    import approx_eval_pkg::*;
#(
    parameter int N_IN = DEF_N_IN,
    parameter int N_OUT = DEF_N_OUT,
    parameter int SETTLE = DEF_SETTLE
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         start,
    output logic [N_IN-1:0]                              pi_o,
    input  logic [N_OUT-1:0]                             exact_po,
    input  logic [N_OUT-1:0]                             approx_po,
    output logic                                         busy,
    output logic                                         done,
    output logic [N_IN:0]                                err_count,
    output logic [sum_width(N_IN, $clog2(N_OUT+1))-1:0]  hd_sum,
    output logic [sum_width(N_IN, N_OUT)-1:0]            abs_err_sum,
    output logic [N_OUT-1:0]                             max_abs_err
);
    localparam int PW = $clog2(N_OUT+1);
    localparam int HD_W = sum_width(N_IN, PW);
    localparam int AE_W = sum_width(N_IN, N_OUT);
    localparam int SW = SETTLE > 0 ? $clog2(SETTLE+1) : 1;
    localparam logic [N_IN:0] LAST = {1'b0, {N_IN{1'b1}}};
    localparam state_t FIRST = SETTLE > 0 ? WAIT : SAMPLE;

    state_t state;
    logic [N_IN:0] vec;
    logic [SW-1:0] cnt;
    logic mismatch;
    logic [PW-1:0] hd;
    logic [N_OUT-1:0] abs_diff;

    error_metric_unit #(.N_OUT(N_OUT)) u_metric (
        .exact_po  (exact_po),
        .approx_po (approx_po),
        .mismatch  (mismatch),
        .hd        (hd),
        .abs_diff  (abs_diff)
    );

    assign pi_o = vec[N_IN-1:0];

    // sweep sequencer and metric accumulation
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            vec <= '0;
            cnt <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            err_count <= '0;
            hd_sum <= '0;
            abs_err_sum <= '0;
            max_abs_err <= '0;
        end else begin
            case (state)
                IDLE, DONE: if (start) begin
                    state <= FIRST;
                    vec <= '0;
                    cnt <= '0;
                    busy <= 1'b1;
                    done <= 1'b0;
                    err_count <= '0;
                    hd_sum <= '0;
                    abs_err_sum <= '0;
                    max_abs_err <= '0;
                end
                WAIT: begin
                    cnt <= cnt == SW'(SETTLE-1) ? '0 : cnt + SW'(1);
                    if (cnt == SW'(SETTLE-1)) state <= SAMPLE;
                end
                SAMPLE: begin
                    err_count <= err_count + (N_IN+1)'(mismatch);
                    hd_sum <= hd_sum + HD_W'(hd);
                    abs_err_sum <= abs_err_sum + AE_W'(abs_diff);
                    if (abs_diff > max_abs_err) max_abs_err <= abs_diff;
                    if (vec == LAST) begin
                        state <= DONE;
                        busy <= 1'b0;
                        done <= 1'b1;
                    end else begin
                        vec <= vec + 1'b1;
                        state <= FIRST;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_approx_error_monitor.sv
// tb_approx_error_monitor: scoreboard bench for the sweep results, timing and reset behaviour
module tb_approx_error_monitor;

    typedef struct {
        int err;
        int hd;
        int ae;
        int mx;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start1 = 1'b0;
    logic start2 = 1'b0;
    int mode1 = 0;

    logic [6:0] pi1, pi2;
    logic [3:0] exact1, approx1, exact2;
    logic busy1, done1, busy2, done2;
    logic [7:0] err1, err2;
    logic [9:0] hd1, hd2;
    logic [10:0] ae1, ae2;
    logic [3:0] mx1, mx2;

    res_t sb[$];
    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // external exact and approximate circuits driven by each sweep
    always_comb begin
        exact1 = pi1[3:0];
        approx1 = mode1 == 0 ? exact1 : mode1 == 1 ? exact1 ^ 4'b0001 : 4'b0000;
        exact2 = pi2[3:0];
    end

    approx_error_monitor #(.N_IN(7), .N_OUT(4), .SETTLE(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .pi_o(pi1),
        .exact_po(exact1), .approx_po(approx1),
        .busy(busy1), .done(done1), .err_count(err1),
        .hd_sum(hd1), .abs_err_sum(ae1), .max_abs_err(mx1)
    );

    approx_error_monitor #(.N_IN(7), .N_OUT(4), .SETTLE(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .pi_o(pi2),
        .exact_po(exact2), .approx_po(exact2),
        .busy(busy2), .done(done2), .err_count(err2),
        .hd_sum(hd2), .abs_err_sum(ae2), .max_abs_err(mx2)
    );

    function automatic res_t model(input int mode);
        res_t r;
        r = '{0, 0, 0, 0};
        for (int v = 0; v < 128; v++) begin
            int e, a, x, d;
            e = v % 16;
            a = mode == 0 ? e : mode == 1 ? (e ^ 1) : 0;
            x = e ^ a;
            d = a >= e ? a - e : e - a;
            if (x != 0) r.err++;
            for (int b = 0; b < 4; b++) r.hd += (x >> b) & 1;
            r.ae += d;
            if (d > r.mx) r.mx = d;
        end
        return r;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if ({pi1, busy1, done1, err1, hd1, ae1, mx1} !== '0) begin
            n_bad++;
            $display("FAIL reset_dut1: got pi=%0d busy=%0b done=%0b err=%0d hd=%0d ae=%0d mx=%0d want all 0", pi1, busy1, done1, err1, hd1, ae1, mx1);
        end
        n_vec++;
        if ({pi2, busy2, done2, err2, hd2, ae2, mx2} !== '0) begin
            n_bad++;
            $display("FAIL reset_dut2: got pi=%0d busy=%0b done=%0b want all 0", pi2, busy2, done2);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_sweep(input int mode, input string name);
        res_t e;
        int cyc;
        mode1 = mode;
        sb.push_back(model(mode));
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        n_vec++;
        if (busy1 !== 1'b1 || done1 !== 1'b0 || pi1 !== 7'd0 || {err1, hd1, ae1, mx1} !== '0) begin
            n_bad++;
            $display("FAIL %s_start: got busy=%0b done=%0b pi=%0d err=%0d hd=%0d ae=%0d mx=%0d want busy=1 done=0 rest 0", name, busy1, done1, pi1, err1, hd1, ae1, mx1);
        end
        cyc = 0;
        while (done1 !== 1'b1 && cyc < 1000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        n_vec++;
        if (cyc != 256) begin
            n_bad++;
            $display("FAIL %s_latency: got %0d cycles want 256", name, cyc);
        end
        e = sb.pop_front();
        n_vec++;
        if (err1 !== 8'(e.err) || hd1 !== 10'(e.hd) || ae1 !== 11'(e.ae) || mx1 !== 4'(e.mx) || busy1 !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_result: got err=%0d hd=%0d ae=%0d mx=%0d busy=%0b want err=%0d hd=%0d ae=%0d mx=%0d busy=0", name, err1, hd1, ae1, mx1, busy1, e.err, e.hd, e.ae, e.mx);
        end
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if (done1 !== 1'b1 || err1 !== 8'(e.err) || ae1 !== 11'(e.ae)) begin
            n_bad++;
            $display("FAIL %s_hold: got done=%0b err=%0d ae=%0d want done=1 err=%0d ae=%0d", name, done1, err1, ae1, e.err, e.ae);
        end
    endtask

    task automatic test_exact_match();
        run_sweep(0, "exact_match");
    endtask

    task automatic test_lsb_flip();
        run_sweep(1, "lsb_flip");
    endtask

    task automatic test_approx_zero();
        run_sweep(2, "approx_zero");
    endtask

    task automatic test_settle2_timing();
        int cyc;
        @(negedge clk);
        start2 = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        cyc = 0;
        n_vec++;
        if (busy2 !== 1'b1 || pi2 !== 7'd0) begin
            n_bad++;
            $display("FAIL settle2_busy_rise: got busy=%0b pi=%0d want busy=1 pi=0", busy2, pi2);
        end
        while (done2 !== 1'b1 && cyc < 1000) begin
            if (cyc == 49) start2 = 1'b1;
            @(posedge clk);
            #1;
            start2 = 1'b0;
            cyc++;
            if (cyc < 384) begin
                n_vec++;
                if (pi2 !== 7'(cyc / 3) || busy2 !== 1'b1) begin
                    n_bad++;
                    $display("FAIL settle2_vec@%0d: got pi=%0d busy=%0b want pi=%0d busy=1", cyc, pi2, busy2, cyc / 3);
                end
            end
        end
        n_vec++;
        if (cyc != 384 || busy2 !== 1'b0) begin
            n_bad++;
            $display("FAIL settle2_done: got %0d cycles busy=%0b want 384 busy=0", cyc, busy2);
        end
        n_vec++;
        if ({err2, hd2, ae2, mx2} !== '0) begin
            n_bad++;
            $display("FAIL settle2_result: got err=%0d hd=%0d ae=%0d mx=%0d want 0", err2, hd2, ae2, mx2);
        end
    endtask

    task automatic test_reset_mid_sweep();
        int cyc;
        mode1 = 1;
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        cyc = 0;
        while (pi1 !== 7'd40 && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        n_vec++;
        if (pi1 !== 7'd40 || err1 == '0) begin
            n_bad++;
            $display("FAIL mid_reach40: got pi=%0d err=%0d want pi=40 err>0", pi1, err1);
        end
        rst = 1'b1;
        start1 = 1'b1;
        @(posedge clk);
        #1;
        n_vec++;
        if ({pi1, busy1, done1, err1, hd1, ae1, mx1} !== '0) begin
            n_bad++;
            $display("FAIL mid_reset: got pi=%0d busy=%0b done=%0b err=%0d hd=%0d ae=%0d mx=%0d want all 0", pi1, busy1, done1, err1, hd1, ae1, mx1);
        end
        @(negedge clk);
        rst = 1'b0;
        start1 = 1'b0;
        @(posedge clk);
        #1;
        n_vec++;
        if (busy1 !== 1'b0 || err1 !== '0) begin
            n_bad++;
            $display("FAIL mid_idle: got busy=%0b err=%0d want busy=0 err=0", busy1, err1);
        end
        run_sweep(1, "after_reset");
    endtask

    task automatic test_back_to_back();
        run_sweep(2, "b2b_first");
        run_sweep(2, "b2b_second");
    endtask

    initial begin
        test_reset();
        test_exact_match();
        test_lsb_flip();
        test_approx_zero();
        test_settle2_timing();
        test_reset_mid_sweep();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
